// File: rtl/instr_fetch_if.sv
// Instruction-fetch bus bundle.
// Groups the instruction-memory request/response channel, the processor
// redirect strobe and the decode-side valid/ready channel.
//   master : the fetch unit's view (drives imem_req/addr and out_*)
//   slave  : the environment's view (memory, processor, decode)
interface instr_fetch_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        out_ready;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// Issues one split-transaction request at a time to instruction memory,
// buffers up to two fetched {instr, pc} entries for decode, and handles
// PC redirects by flushing the buffer and discarding any in-flight response.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - instr_fetch_if.master: imem_req/addr/rvalid/rdata, redirect/
//          redirect_pc, out_valid/out_instr/out_pc/out_ready
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.master bus
);

  localparam logic [15:0] ResetPcAligned = {RESET_PC[15:1], 1'b0};

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] req_pc_q;
  logic [1:0]  count_q;
  // Entry 0 is always the head; a pop shifts entry 1 down.
  logic [15:0] e0_instr_q, e0_pc_q;
  logic [15:0] e1_instr_q, e1_pc_q;

  logic issue, push, pop;

  always_comb begin
    issue = (state_q == StIdle) && (count_q < 2'd2) && !bus.redirect && !rst;
    push  = (state_q == StWait) && bus.imem_rvalid && !bus.redirect;
    // Gated by rst so decode never sees a stale entry during reset.
    bus.out_valid = (count_q != 2'd0) && !rst;
    pop           = bus.out_valid && bus.out_ready;
    bus.imem_req  = issue;
    bus.imem_addr = pc_q;
    bus.out_instr = e0_instr_q;
    bus.out_pc    = e0_pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= ResetPcAligned;
      req_pc_q   <= '0;
      count_q    <= '0;
      e0_instr_q <= '0;
      e0_pc_q    <= '0;
      e1_instr_q <= '0;
      e1_pc_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (issue) begin
            state_q  <= StWait;
            pc_q     <= pc_q + 16'd2;
            req_pc_q <= pc_q;
          end
        end
        StWait: begin
          // Redirect without a response means the reply is still coming and
          // must be swallowed; with a response it is simply discarded here.
          if (bus.redirect && !bus.imem_rvalid) begin
            state_q <= StDrop;
          end else if (bus.imem_rvalid) begin
            state_q <= StIdle;
          end
        end
        StDrop: begin
          if (bus.imem_rvalid) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (bus.redirect) begin
        pc_q    <= {bus.redirect_pc[15:1], 1'b0};
        count_q <= '0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (count_q == 2'd0) begin
              e0_instr_q <= bus.imem_rdata;
              e0_pc_q    <= req_pc_q;
            end else begin
              e1_instr_q <= bus.imem_rdata;
              e1_pc_q    <= req_pc_q;
            end
            count_q <= count_q + 2'd1;
          end
          2'b01: begin
            e0_instr_q <= e1_instr_q;
            e0_pc_q    <= e1_pc_q;
            count_q    <= count_q - 2'd1;
          end
          2'b11: begin
            if (count_q == 2'd1) begin
              e0_instr_q <= bus.imem_rdata;
              e0_pc_q    <= req_pc_q;
            end else begin
              e0_instr_q <= e1_instr_q;
              e0_pc_q    <= e1_pc_q;
              e1_instr_q <= bus.imem_rdata;
              e1_pc_q    <= req_pc_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst2;
  instr_fetch_if bus ();
  instr_fetch_if bus2 ();

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  instr_fetch #(.RESET_PC(16'hFFFE)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;

  ent_t        exp_q[$];
  int          passed = 0;
  int          total  = 0;
  bit          mem_auto = 1'b0;
  logic        prev_req = 1'b0;
  logic [15:0] prev_addr = '0;

  function automatic logic [15:0] data_of(input logic [15:0] a);
    return a ^ 16'hC35A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Applies one cycle of inputs and settles. With mem_auto a 1-cycle memory
  // answers the previous cycle's request. push_exp marks a response the fetch
  // unit must accept. Pops are checked against the scoreboard here.
  task automatic drive(input logic r_rst, input logic rv, input logic [15:0] rdata,
                       input logic push_exp, input logic [15:0] exp_pc,
                       input logic redir, input logic [15:0] rpc, input logic rdy);
    ent_t e;
    rst             = r_rst;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.out_ready   = rdy;
    if (mem_auto) begin
      rv       = prev_req;
      rdata    = data_of(prev_addr);
      exp_pc   = prev_addr;
      push_exp = prev_req;
    end
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? rdata : 16'h0000;
    #1;
    if (bus.out_valid && rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_instr", {16'd0, bus.out_instr}, {16'd0, e.instr});
        chk("out_pc", {16'd0, bus.out_pc}, {16'd0, e.pc});
      end
    end
    if (redir || r_rst) exp_q.delete();
    else if (rv && push_exp) exp_q.push_back('{instr: rdata, pc: exp_pc});
    prev_req  = bus.imem_req;
    prev_addr = bus.imem_addr;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    step();
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    step();
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [15:0] addr);
    chk({tag, "_req"}, {31'd0, bus.imem_req}, {31'd0, req});
    if (req) chk({tag, "_addr"}, {16'd0, bus.imem_addr}, {16'd0, addr});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst2 = 1'b1;
    bus2.imem_rvalid = 1'b0; bus2.imem_rdata = '0; bus2.redirect = 1'b0;
    bus2.redirect_pc = '0;   bus2.out_ready = 1'b1;

    // Reset, with a redirect asserted under reset that must be ignored.
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 16'h0040, 1'b0);
    step();
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 16'h0040, 1'b1);
    chk_req("rst", 1'b0, '0);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_instr", {16'd0, bus.out_instr}, 32'd0);
    chk("rst_pc", {16'd0, bus.out_pc}, 32'd0);
    step();

    // Streaming with a 1-cycle memory and decode always ready.
    mem_auto = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1); chk_req("s0", 1'b1, 16'h0000); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1); chk_req("s1", 1'b0, '0);
    chk("s1_valid", {31'd0, bus.out_valid}, 32'd0); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1); chk_req("s2", 1'b1, 16'h0002);
    chk("s2_valid", {31'd0, bus.out_valid}, 32'd1); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1); chk_req("s4", 1'b1, 16'h0004); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1); chk_req("s6", 1'b1, 16'h0006); step();

    // Back-pressure: buffer fills at two entries and requests stop.
    do_reset();
    prev_req = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0); chk_req("b0", 1'b1, 16'h0000); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0); chk_req("b2", 1'b1, 16'h0002); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0); chk_req("b4", 1'b0, '0);
    chk("b4_head", {16'd0, bus.out_pc}, 32'h0000); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0); chk_req("b5", 1'b0, '0); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1); chk_req("b6", 1'b0, '0); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1); chk_req("b7", 1'b1, 16'h0004); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1); step();
    chk("b_drained", exp_q.size(), 32'd0);

    // Redirect while waiting: late response dropped, refetch at 0x0100.
    mem_auto = 1'b0;
    do_reset();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1); chk_req("r0", 1'b1, 16'h0000); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 16'h0101, 1'b1); chk_req("r1", 1'b0, '0); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1); chk_req("r2_drop", 1'b0, '0); step();
    drive(1'b0, 1'b1, 16'hDEAD, 1'b0, '0, 1'b0, '0, 1'b1); chk_req("r3_late", 1'b0, '0); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1); chk_req("r4", 1'b1, 16'h0100);
    chk("r4_valid", {31'd0, bus.out_valid}, 32'd0); step();
    drive(1'b0, 1'b1, data_of(16'h0100), 1'b1, 16'h0100, 1'b0, '0, 1'b1);
    chk("r5_valid", {31'd0, bus.out_valid}, 32'd0); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    chk("r6_valid", {31'd0, bus.out_valid}, 32'd1); step();

    // Redirect coincident with a response while one entry is buffered.
    mem_auto = 1'b1;
    do_reset();
    prev_req = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0); chk_req("c2", 1'b1, 16'h0002); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 16'h0300, 1'b0); chk_req("c3", 1'b0, '0); step();
    mem_auto = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1); chk_req("c4", 1'b1, 16'h0300);
    chk("c4_valid", {31'd0, bus.out_valid}, 32'd0); step();

    // Reset mid-wait with a buffered entry; stale response after release.
    do_reset();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0); step();
    drive(1'b0, 1'b1, data_of(16'h0000), 1'b1, 16'h0000, 1'b0, '0, 1'b0); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0); chk_req("m2", 1'b1, 16'h0002);
    chk("m2_valid", {31'd0, bus.out_valid}, 32'd1); step();
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0); chk_req("m3", 1'b0, '0);
    chk("m3_valid", {31'd0, bus.out_valid}, 32'd0); step();
    drive(1'b0, 1'b1, 16'hBEEF, 1'b0, '0, 1'b0, '0, 1'b1); chk_req("m4", 1'b1, 16'h0000);
    chk("m4_valid", {31'd0, bus.out_valid}, 32'd0); step();
    drive(1'b0, 1'b1, data_of(16'h0000), 1'b1, 16'h0000, 1'b0, '0, 1'b1); step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    chk("m6_valid", {31'd0, bus.out_valid}, 32'd1); step();
    chk("m_drained", exp_q.size(), 32'd0);

    // Wrap-around from RESET_PC = 0xFFFE.
    rst2 = 1'b0; #1;
    chk("w0_req", {31'd0, bus2.imem_req}, 32'd1);
    chk("w0_addr", {16'd0, bus2.imem_addr}, 32'h0000FFFE);
    step();
    bus2.imem_rvalid = 1'b1; bus2.imem_rdata = 16'h1234; #1;
    chk("w1_req", {31'd0, bus2.imem_req}, 32'd0);
    step();
    bus2.imem_rvalid = 1'b0; bus2.imem_rdata = '0; #1;
    chk("w2_req", {31'd0, bus2.imem_req}, 32'd1);
    chk("w2_addr", {16'd0, bus2.imem_addr}, 32'h00000000);
    chk("w2_pc", {16'd0, bus2.out_pc}, 32'h0000FFFE);
    chk("w2_instr", {16'd0, bus2.out_instr}, 32'h00001234);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
